// File: rtl/timer_unit.sv
// timer_unit: prescaler-ticked up-counter with compare, overflow, one-shot/auto-reload and sticky IRQ flags.
// Optional input capture is compiled in when TIMER_CAPTURE_EN is defined.
module timer_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             presc_clk,
    input  logic             presc_bypass,
    input  logic             tmr_en,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cmp_val,
    input  logic             load_strb,
    input  logic             flag_clr,
`ifdef TIMER_CAPTURE_EN
    input  logic             cap_in,
    output logic [WIDTH-1:0] cap_val,
    output logic             cap_flag,
`endif
    output logic [WIDTH-1:0] count,
    output logic             match_flag,
    output logic             ovf_flag,
    output logic             irq,
    output logic             running
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [2:0]       sync_q, sync_d;
    logic [WIDTH-1:0] count_q, count_d, count_inc;
    logic             match_q, match_d, ovf_q, ovf_d;
    logic             tick, step, wrap, match_set;

    // sync_q = {sd, s2, s1}; a rising edge of s2 becomes a one-clk tick
    always_comb begin
        sync_d    = {sync_q[1:0], presc_clk};
        tick      = presc_bypass | (sync_q[1] & ~sync_q[2]);
        step      = (state_q == RUN) & tick & ~load_strb;
        wrap      = step & (&count_q);
        count_inc = count_q + WIDTH'(1);
        match_set = step & ~wrap & (count_inc == cmp_val);
        count_d   = (load_strb | wrap) ? load_val : step ? count_inc : count_q;
        match_d   = match_set | (match_q & ~flag_clr);
        ovf_d     = wrap | (ovf_q & ~flag_clr);
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = tmr_en ? RUN : IDLE;
            RUN:     state_d = !tmr_en ? IDLE : (wrap && !auto_reload) ? DONE : RUN;
            DONE:    state_d = tmr_en ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            sync_q  <= '0;
            count_q <= '0;
            match_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            count_q <= count_d;
            match_q <= match_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef TIMER_CAPTURE_EN
    logic [2:0]       cap_sync_q, cap_sync_d;
    logic [WIDTH-1:0] cap_val_q, cap_val_d;
    logic             cap_flag_q, cap_flag_d, cap_rise;

    // two-stage synchroniser plus one history bit for edge detection
    always_comb begin
        cap_sync_d = {cap_sync_q[1:0], cap_in};
        cap_rise   = cap_sync_q[1] & ~cap_sync_q[2];
        cap_val_d  = cap_rise ? count_q : cap_val_q;
        cap_flag_d = cap_rise | (cap_flag_q & ~flag_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cap_sync_q <= '0;
            cap_val_q  <= '0;
            cap_flag_q <= 1'b0;
        end else begin
            cap_sync_q <= cap_sync_d;
            cap_val_q  <= cap_val_d;
            cap_flag_q <= cap_flag_d;
        end
    end

    always_comb begin
        cap_val  = cap_val_q;
        cap_flag = cap_flag_q;
        irq      = match_q | ovf_q | cap_flag_q;
    end
`else
    always_comb irq = match_q | ovf_q;
`endif

    always_comb begin
        count      = count_q;
        match_flag = match_q;
        ovf_flag   = ovf_q;
        running    = (state_q == RUN);
    end
endmodule

// File: tb/tb_timer_unit.sv
// tb_timer_unit: table vectors, directed corner sequences and randomized stimulus against a cycle model.
module tb_timer_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0, presc_clk = 1'b0, presc_bypass = 1'b1, tmr_en = 1'b1, auto_reload = 1'b0;
    logic [15:0] load_val = '0, cmp_val = '0;
    logic        load_strb = 1'b0, flag_clr = 1'b0, cap_in = 1'b0;
    logic [15:0] count;
    logic        match_flag, ovf_flag, irq, running;
`ifdef TIMER_CAPTURE_EN
    logic [15:0] cap_val;
    logic        cap_flag;
`endif

    always #5 clk = ~clk;

    timer_unit #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .presc_clk(presc_clk), .presc_bypass(presc_bypass),
        .tmr_en(tmr_en), .auto_reload(auto_reload), .load_val(load_val), .cmp_val(cmp_val),
        .load_strb(load_strb), .flag_clr(flag_clr),
`ifdef TIMER_CAPTURE_EN
        .cap_in(cap_in), .cap_val(cap_val), .cap_flag(cap_flag),
`endif
        .count(count), .match_flag(match_flag), .ovf_flag(ovf_flag), .irq(irq), .running(running)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: modes 0=idle 1=run 2=done; tick/capture edges come from sample histories
    int m_cnt = 0, m_mode = 0, m_capv = 0;
    bit m_match = 0, m_ovf = 0, m_capf = 0;
    bit ph[$] = '{0, 0, 0};
    bit ch[$] = '{0, 0, 0};

    task automatic model_edge();
        bit tk, cr, ov, mt;
        int pre;
        if (!rst) begin
            m_cnt = 0; m_mode = 0; m_capv = 0; m_match = 0; m_ovf = 0; m_capf = 0;
            ph = '{0, 0, 0};
            ch = '{0, 0, 0};
            return;
        end
        tk = presc_bypass || (ph[1] && !ph[0]);
        cr = ch[1] && !ch[0];
        ph.push_back(presc_clk); void'(ph.pop_front());
        ch.push_back(cap_in); void'(ch.pop_front());
        pre = m_cnt; ov = 0; mt = 0;
        if (load_strb) m_cnt = load_val;
        else if (m_mode == 1 && tk) begin
            if (m_cnt == 65535) begin ov = 1; m_cnt = load_val; end
            else begin m_cnt = m_cnt + 1; mt = (m_cnt == cmp_val); end
        end
        m_match = mt || (m_match && !flag_clr);
        m_ovf   = ov || (m_ovf && !flag_clr);
        if (cr) m_capv = pre;
        m_capf  = cr || (m_capf && !flag_clr);
        if (m_mode == 0) m_mode = tmr_en ? 1 : 0;
        else if (m_mode == 1) m_mode = !tmr_en ? 0 : (ov && !auto_reload) ? 2 : 1;
        else m_mode = tmr_en ? 2 : 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model", {count, match_flag, ovf_flag, running, irq},
            {m_cnt[15:0], m_match, m_ovf, m_mode == 1, m_match | m_ovf | m_capf});
`ifdef TIMER_CAPTURE_EN
        chk("model_cap", {cap_val, cap_flag}, {m_capv[15:0], m_capf});
`endif
    endtask

    typedef struct {
        logic rst, byp, en, ar, strb, clr;
        logic [15:0] lv, cv, e_cnt;
        logic e_m, e_o, e_run;
    } vec_t;

    function automatic vec_t mk(logic r, logic b, logic e, logic a, logic s, logic c,
                                logic [15:0] lv, logic [15:0] cv, logic [15:0] ec,
                                logic em, logic eo, logic er);
        vec_t v;
        v.rst = r; v.byp = b; v.en = e; v.ar = a; v.strb = s; v.clr = c;
        v.lv = lv; v.cv = cv; v.e_cnt = ec; v.e_m = em; v.e_o = eo; v.e_run = er;
        return v;
    endfunction

    vec_t tbl[15];

    initial begin
        tbl[0]  = mk(0, 1, 1, 0, 0, 0, 16'h0000, 16'd5, 16'h0000, 0, 0, 0);
        tbl[1]  = tbl[0];
        tbl[2]  = tbl[0];
        tbl[3]  = mk(1, 1, 0, 0, 1, 0, 16'h0000, 16'd5, 16'h0000, 0, 0, 0);
        tbl[4]  = mk(1, 1, 1, 0, 0, 0, 16'h0000, 16'd5, 16'h0000, 0, 0, 1);
        tbl[5]  = mk(1, 1, 1, 0, 0, 0, 16'h0000, 16'd5, 16'h0001, 0, 0, 1);
        tbl[6]  = mk(1, 1, 1, 0, 0, 0, 16'h0000, 16'd5, 16'h0002, 0, 0, 1);
        tbl[7]  = mk(1, 1, 1, 0, 0, 0, 16'h0000, 16'd5, 16'h0003, 0, 0, 1);
        tbl[8]  = mk(1, 1, 1, 0, 0, 0, 16'h0000, 16'd5, 16'h0004, 0, 0, 1);
        tbl[9]  = mk(1, 1, 1, 0, 0, 0, 16'h0000, 16'd5, 16'h0005, 1, 0, 1);
        tbl[10] = mk(1, 1, 1, 0, 0, 1, 16'h0000, 16'd5, 16'h0006, 0, 0, 1);
        tbl[11] = mk(1, 1, 1, 0, 1, 0, 16'h0100, 16'd5, 16'h0100, 0, 0, 1);
        tbl[12] = mk(1, 1, 1, 0, 1, 0, 16'h0004, 16'd5, 16'h0004, 0, 0, 1);
        tbl[13] = mk(1, 1, 1, 0, 0, 1, 16'h0004, 16'd5, 16'h0005, 1, 0, 1);
        tbl[14] = mk(0, 1, 1, 0, 0, 0, 16'h0004, 16'd5, 16'h0000, 0, 0, 0);

        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].rst; presc_bypass = tbl[i].byp; tmr_en = tbl[i].en; auto_reload = tbl[i].ar;
            load_strb = tbl[i].strb; flag_clr = tbl[i].clr; load_val = tbl[i].lv; cmp_val = tbl[i].cv;
            step();
            chk($sformatf("table[%0d]", i), {count, match_flag, ovf_flag, irq, running},
                {tbl[i].e_cnt, tbl[i].e_m, tbl[i].e_o, tbl[i].e_m | tbl[i].e_o, tbl[i].e_run});
        end

        // prescaled ticks: period 8, count moves on the 3rd edge after each rise
        rst = 1; presc_bypass = 0; presc_clk = 0; tmr_en = 1; load_strb = 0; flag_clr = 0;
        load_val = 0; cmp_val = 16'h7777;
        repeat (4) step();
        chk("presc_start", {count, running}, {16'h0000, 1'b1});
        for (int k = 0; k < 32; k++) begin
            presc_clk = (k % 8) < 4;
            step();
            chk($sformatf("presc[%0d]", k), count, 16'((k + 6) / 8));
        end

        // auto-reload wrap
        presc_clk = 0; presc_bypass = 1; auto_reload = 1; load_val = 16'hFFFD; load_strb = 1;
        step();
        chk("ar_load", count, 16'hFFFD);
        load_strb = 0;
        step(); chk("ar_fffe", {count, ovf_flag, running}, {16'hFFFE, 1'b0, 1'b1});
        step(); chk("ar_ffff", {count, ovf_flag, running}, {16'hFFFF, 1'b0, 1'b1});
        step(); chk("ar_wrap", {count, ovf_flag, irq, running}, {16'hFFFD, 1'b1, 1'b1, 1'b1});
        step(); chk("ar_after", {count, running}, {16'hFFFE, 1'b1});

        // one-shot: halt in DONE until tmr_en is dropped and re-raised
        auto_reload = 0; load_strb = 1; flag_clr = 1;
        step(); chk("os_load", {count, ovf_flag}, {16'hFFFD, 1'b0});
        load_strb = 0; flag_clr = 0;
        step(); step();
        chk("os_ffff", count, 16'hFFFF);
        step(); chk("os_wrap", {count, ovf_flag, running}, {16'hFFFD, 1'b1, 1'b0});
        step(); step();
        chk("os_hold", {count, running}, {16'hFFFD, 1'b0});
        tmr_en = 0; step(); chk("os_idle", {count, running}, {16'hFFFD, 1'b0});
        tmr_en = 1; step(); chk("os_rearm", {count, running}, {16'hFFFD, 1'b1});
        step(); chk("os_resume", count, 16'hFFFE);

`ifdef TIMER_CAPTURE_EN
        tmr_en = 0; step();
        load_val = 16'h0042; load_strb = 1; flag_clr = 1; step();
        load_strb = 0; flag_clr = 0; cap_in = 1;
        repeat (3) step();
        chk("capture", {cap_val, cap_flag, irq, count}, {16'h0042, 1'b1, 1'b1, 16'h0042});
        cap_in = 0; tmr_en = 1;
`endif

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(199) != 0);
            if ($urandom_range(19) == 0) tmr_en = ~tmr_en;
            if ($urandom_range(49) == 0) auto_reload = ~auto_reload;
            if ($urandom_range(99) == 0) presc_bypass = ~presc_bypass;
            if ($urandom_range(2) == 0) presc_clk = ~presc_clk;
            if ($urandom_range(9) == 0) cap_in = ~cap_in;
`ifndef TIMER_CAPTURE_EN
            cap_in = 0;
`endif
            load_strb = ($urandom_range(15) == 0);
            flag_clr  = ($urandom_range(15) == 0);
            load_val  = ($urandom_range(3) == 0) ? (16'hFFF0 | 16'($urandom_range(15))) : 16'($urandom);
            cmp_val   = ($urandom_range(1) == 0) ? 16'(m_cnt + $urandom_range(8)) : 16'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
